line_buf_pp: RTL and testbench

- Parametrised ping-pong scanline buffer with two banks of 2^AW x DW words.
- The sprite/tile engine writes into the write bank. Video output reads the other bank, and each read location is cleared behind it.
- Optional priority mode: first-opaque-writer-wins with transparent-pixel skip.
- Replaces fixed 1024x11 line buffers in the video pipeline.
- On reset, a clear sequencer initialises both banks before use.

---
 rtl/line_buf_pp.sv | 124 ++++++++++++
 tb/tb_line_buf_pp.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_buf_pp.sv
// Ping-pong scanline buffer: one bank takes engine writes while the other is read
// out and cleared behind the reader. An init sweep clears both banks after reset.
module line_buf_pp #(
  parameter int AW = 9,
  parameter int DW = 11,
  parameter int TW = 4,
  parameter int MODE = 0,
  parameter logic [DW-1:0] CLRVAL = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          swap,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_adr,
  input  logic [DW-1:0] wr_dat,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_adr,
  output logic [DW-1:0] rd_dat,
  output logic          rd_vld,
  output logic          bank,
  output logic          busy
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t        state_reg, state_next;
  logic [AW-1:0] cnt_reg;
  logic [DW-1:0] mem [2][DEPTH];
  logic          bank_reg;

  logic          s1_vld_reg, s1_bank_reg;
  logic [AW-1:0] s1_adr_reg;
  logic [DW-1:0] s1_dat_reg, s1_old_reg;

  logic          clr_pend_reg, clr_bank_reg;
  logic [AW-1:0] clr_adr_reg;

  logic [DW-1:0] rd_dat_reg;
  logic          rd_vld_reg;

  logic          run, rd_bank, commit_we;
  logic [DW-1:0] s1_old_next, rd_dat_next;

  assign run     = (state_reg == RUN);
  assign rd_bank = ~bank_reg;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= CLEAR;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg == CLEAR);
    if (state_reg == CLEAR && cnt_reg == '1) state_next = RUN;
  end

  // Priority mode: a write lands only if it is opaque and the word beneath is transparent.
  always_comb begin
    commit_we = s1_vld_reg;
    if (MODE != 0)
      commit_we = s1_vld_reg && (s1_dat_reg[TW-1:0] != '0) && (s1_old_reg[TW-1:0] == '0);
  end

  // Bypass paths: the committing write wins over a pending clear, which wins over memory.
  always_comb begin
    s1_old_next = mem[bank_reg][wr_adr];
    if (clr_pend_reg && clr_bank_reg == bank_reg && clr_adr_reg == wr_adr)
      s1_old_next = CLRVAL;
    if (commit_we && s1_bank_reg == bank_reg && s1_adr_reg == wr_adr)
      s1_old_next = s1_dat_reg;

    rd_dat_next = mem[rd_bank][rd_adr];
    if (clr_pend_reg && clr_bank_reg == rd_bank && clr_adr_reg == rd_adr)
      rd_dat_next = CLRVAL;
    if (commit_we && s1_bank_reg == rd_bank && s1_adr_reg == rd_adr)
      rd_dat_next = s1_dat_reg;
    if (!run)
      rd_dat_next = CLRVAL;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bank_reg     <= 1'b0;
      rd_dat_reg   <= CLRVAL;
      rd_vld_reg   <= 1'b0;
      cnt_reg      <= '0;
      s1_vld_reg   <= 1'b0;
      clr_pend_reg <= 1'b0;
    end else begin
      if (!run) cnt_reg <= cnt_reg + AW'(1);
      if (run && swap) bank_reg <= ~bank_reg;
      s1_vld_reg   <= run && wr_en;
      clr_pend_reg <= run && rd_en;
      rd_vld_reg   <= rd_en;
      if (rd_en) rd_dat_reg <= rd_dat_next;
    end
  end

  // Tags travel with each stage so in-flight work keeps its pre-swap bank.
  always_ff @(posedge clk) begin
    s1_adr_reg   <= wr_adr;
    s1_dat_reg   <= wr_dat;
    s1_bank_reg  <= bank_reg;
    s1_old_reg   <= s1_old_next;
    clr_adr_reg  <= rd_adr;
    clr_bank_reg <= rd_bank;
  end

  always_ff @(posedge clk) begin
    if (!run) begin
      mem[0][cnt_reg] <= CLRVAL;
      mem[1][cnt_reg] <= CLRVAL;
    end else begin
      if (commit_we)    mem[s1_bank_reg][s1_adr_reg] <= s1_dat_reg;
      if (clr_pend_reg) mem[clr_bank_reg][clr_adr_reg] <= CLRVAL;
    end
  end

  assign rd_dat = rd_dat_reg;
  assign rd_vld = rd_vld_reg;
  assign bank   = bank_reg;
endmodule

// File: tb/tb_line_buf_pp.sv
// Bench for line_buf_pp: overwrite and priority instances share stimulus and are
// checked against a per-cycle array model of both banks.
module tb_line_buf_pp;
  localparam int AW = 9;
  localparam int DW = 11;
  localparam int TW = 4;
  localparam int DEPTH = 512;
  localparam logic [DW-1:0] CLR = '0;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          swap = 1'b0, wr_en = 1'b0, rd_en = 1'b0;
  logic [AW-1:0] wr_adr = '0, rd_adr = '0;
  logic [DW-1:0] wr_dat = '0;
  logic [DW-1:0] rd_dat0, rd_dat1;
  logic          rd_vld0, rd_vld1, bank0, bank1, busy0, busy1;

  always #5 clk = ~clk;

  line_buf_pp #(.AW(AW), .DW(DW), .TW(TW), .MODE(0), .CLRVAL(CLR)) dut0 (
    .clk(clk), .reset(reset), .swap(swap), .wr_en(wr_en), .wr_adr(wr_adr),
    .wr_dat(wr_dat), .rd_en(rd_en), .rd_adr(rd_adr), .rd_dat(rd_dat0),
    .rd_vld(rd_vld0), .bank(bank0), .busy(busy0));

  line_buf_pp #(.AW(AW), .DW(DW), .TW(TW), .MODE(1), .CLRVAL(CLR)) dut1 (
    .clk(clk), .reset(reset), .swap(swap), .wr_en(wr_en), .wr_adr(wr_adr),
    .wr_dat(wr_dat), .rd_en(rd_en), .rd_adr(rd_adr), .rd_dat(rd_dat1),
    .rd_vld(rd_vld1), .bank(bank1), .busy(busy1));

  int n_cmp = 0;
  int n_bad = 0;

  // Model: reads see the read bank then clear it; writes apply at acceptance.
  logic [DW-1:0] m0 [2][DEPTH];
  logic [DW-1:0] m1 [2][DEPTH];
  bit            m_bank;
  int            m_clear_left;
  bit            e_vld;
  logic [DW-1:0] e_dat0, e_dat1;

  task automatic step(input bit rst, input bit sw, input bit we, input int wa,
                      input logic [DW-1:0] wd, input bit re, input int ra);
    reset = rst; swap = sw; wr_en = we; wr_adr = AW'(wa); wr_dat = wd;
    rd_en = re; rd_adr = AW'(ra);
    @(posedge clk);
    if (rst) begin
      m_bank = 1'b0; m_clear_left = DEPTH; e_vld = 1'b0; e_dat0 = CLR; e_dat1 = CLR;
      for (int b = 0; b < 2; b++)
        for (int a = 0; a < DEPTH; a++) begin m0[b][a] = CLR; m1[b][a] = CLR; end
    end else if (m_clear_left > 0) begin
      e_vld = re;
      if (re) begin e_dat0 = CLR; e_dat1 = CLR; end
      m_clear_left--;
    end else begin
      e_vld = re;
      if (re) begin
        e_dat0 = m0[!m_bank][ra % DEPTH];
        e_dat1 = m1[!m_bank][ra % DEPTH];
        m0[!m_bank][ra % DEPTH] = CLR;
        m1[!m_bank][ra % DEPTH] = CLR;
      end
      if (we) begin
        m0[m_bank][wa % DEPTH] = wd;
        if (wd[TW-1:0] != '0 && m1[m_bank][wa % DEPTH][TW-1:0] == '0)
          m1[m_bank][wa % DEPTH] = wd;
      end
      if (sw) m_bank = !m_bank;
    end
    #1;
    reset = 1'b0; swap = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    int busy_cnt;
    step(1, 0, 0, 0, '0, 0, 0);
    step(1, 1, 1, 3, 11'h7FF, 0, 0);
    n_cmp++;
    if (busy0 !== 1'b1 || busy1 !== 1'b1 || bank0 !== 1'b0 || rd_vld0 !== 1'b0 || rd_dat0 !== CLR) begin
      n_bad++;
      $display("FAIL reset_state got busy=%b bank=%b vld=%b dat=%h want 1 0 0 %h", busy0, bank0, rd_vld0, rd_dat0, CLR);
    end
    busy_cnt = 0;
    for (int k = 0; k < 2000 && busy0 === 1'b1; k++) begin
      busy_cnt++;
      step(0, (k % 7) == 0, 1, k % 16, 11'h7FF, k == 3, 9);
      if (k == 3) begin
        n_cmp++;
        if (rd_vld0 !== 1'b1 || rd_dat0 !== CLR || rd_vld1 !== 1'b1 || rd_dat1 !== CLR) begin
          n_bad++;
          $display("FAIL clear_read got vld=%b dat=%h / %b %h want 1 %h", rd_vld0, rd_dat0, rd_vld1, rd_dat1, CLR);
        end
      end
    end
    n_cmp++;
    if (busy_cnt != 512 || busy1 !== 1'b0) begin
      n_bad++;
      $display("FAIL busy_len got %0d cycles (busy1=%b) want 512", busy_cnt, busy1);
    end
    n_cmp++;
    if (bank0 !== 1'b0 || bank1 !== 1'b0) begin
      n_bad++;
      $display("FAIL clear_swap_ignored got bank=%b/%b want 0", bank0, bank1);
    end
    $display("test_reset: busy for %0d cycles", busy_cnt);
  endtask

  task automatic test_overwrite();
    step(0, 0, 1, 5, 11'h123, 0, 0);
    step(0, 1, 0, 0, '0, 0, 0);
    step(0, 0, 0, 0, '0, 1, 5);
    n_cmp++;
    if (rd_vld0 !== 1'b1 || rd_dat0 !== 11'h123 || rd_dat1 !== 11'h123) begin
      n_bad++;
      $display("FAIL overwrite_read got %h/%h vld=%b want 123", rd_dat0, rd_dat1, rd_vld0);
    end
    step(0, 0, 0, 0, '0, 1, 5);
    n_cmp++;
    if (rd_vld0 !== 1'b1 || rd_dat0 !== CLR || rd_dat1 !== CLR) begin
      n_bad++;
      $display("FAIL clear_on_read got %h/%h want %h", rd_dat0, rd_dat1, CLR);
    end
    $display("test_overwrite: read 123 then %h", rd_dat0);
  endtask

  task automatic test_priority();
    step(0, 0, 1, 10, 11'h0A3, 0, 0);
    step(0, 0, 1, 10, 11'h0B7, 0, 0);
    step(0, 0, 1, 11, 11'h0F0, 0, 0);
    step(0, 1, 0, 0, '0, 0, 0);
    step(0, 0, 0, 0, '0, 1, 10);
    n_cmp++;
    if (rd_dat0 !== 11'h0B7 || rd_dat1 !== 11'h0A3) begin
      n_bad++;
      $display("FAIL prio_b2b got %h/%h want 0b7/0a3", rd_dat0, rd_dat1);
    end
    step(0, 0, 0, 0, '0, 1, 11);
    n_cmp++;
    if (rd_dat0 !== 11'h0F0 || rd_dat1 !== CLR) begin
      n_bad++;
      $display("FAIL prio_transparent got %h/%h want 0f0/%h", rd_dat0, rd_dat1, CLR);
    end
    step(0, 0, 0, 0, '0, 1, 10);
    n_cmp++;
    if (rd_dat0 !== CLR || rd_dat1 !== CLR) begin
      n_bad++;
      $display("FAIL prio_reclear got %h/%h want %h", rd_dat0, rd_dat1, CLR);
    end
    $display("test_priority: done");
  endtask

  task automatic test_swap_hazard();
    logic [DW-1:0] d;
    d = {7'($urandom), 4'($urandom_range(1, 15))};
    step(0, 1, 1, 20, d, 0, 0);
    step(0, 0, 0, 0, '0, 1, 20);
    n_cmp++;
    if (rd_vld0 !== 1'b1 || rd_dat0 !== d || rd_dat1 !== d || bank0 !== m_bank) begin
      n_bad++;
      $display("FAIL swap_forward got %h/%h bank=%b want %h bank=%b", rd_dat0, rd_dat1, bank0, d, m_bank);
    end
    step(0, 0, 0, 0, '0, 1, 20);
    n_cmp++;
    if (rd_dat0 !== CLR || rd_dat1 !== CLR) begin
      n_bad++;
      $display("FAIL swap_reclear got %h/%h want %h", rd_dat0, rd_dat1, CLR);
    end
    $display("test_swap_hazard: data %h", d);
  endtask

  task automatic test_stream();
    int bad_before;
    bad_before = n_bad;
    for (int line = 0; line < 4; line++) begin
      for (int i = 0; i < DEPTH; i++) begin
        step(0, i == DEPTH - 1, 1, i, DW'($urandom), 1, i);
        n_cmp++;
        if (rd_vld0 !== e_vld || rd_dat0 !== e_dat0 || rd_vld1 !== e_vld || rd_dat1 !== e_dat1) begin
          n_bad++;
          $display("FAIL stream line %0d adr %0d got %h/%h want %h/%h", line, i, rd_dat0, rd_dat1, e_dat0, e_dat1);
        end
      end
      n_cmp++;
      if (bank0 !== m_bank || bank1 !== m_bank) begin
        n_bad++;
        $display("FAIL stream_bank got %b/%b want %b", bank0, bank1, m_bank);
      end
    end
    $display("test_stream: 4 lines, %0d new errors", n_bad - bad_before);
  endtask

  task automatic test_random();
    int bad_before;
    bad_before = n_bad;
    for (int k = 0; k < 3000; k++) begin
      step(0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7),
           DW'($urandom), $urandom_range(0, 2) != 0, $urandom_range(0, 7));
      n_cmp++;
      if (rd_vld0 !== e_vld || rd_dat0 !== e_dat0 || rd_vld1 !== e_vld || rd_dat1 !== e_dat1 ||
          bank0 !== m_bank || bank1 !== m_bank) begin
        n_bad++;
        $display("FAIL random k=%0d got %h/%h v%b b%b want %h/%h v%b b%b", k, rd_dat0, rd_dat1,
                 rd_vld0, bank0, e_dat0, e_dat1, e_vld, m_bank);
      end
    end
    $display("test_random: 3000 cycles, %0d new errors", n_bad - bad_before);
  endtask

  task automatic test_reset_mid();
    int waited;
    if (m_bank == 1'b0) step(0, 1, 0, 0, '0, 0, 0);
    step(0, 0, 1, 3, 11'h155, 1, 4);
    step(0, 0, 1, 3, 11'h2AA, 1, 3);
    step(1, 1, 1, 3, 11'h3FF, 1, 3);
    n_cmp++;
    if (bank0 !== 1'b0 || bank1 !== 1'b0 || rd_vld0 !== 1'b0 || rd_vld1 !== 1'b0 ||
        busy0 !== 1'b1 || busy1 !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_mid got bank=%b vld=%b busy=%b want 0 0 1", bank0, rd_vld0, busy0);
    end
    waited = 0;
    while (busy0 === 1'b1 && waited < 600) begin
      step(0, 0, 1, waited % 8, 11'h3FF, 0, 0);
      waited++;
    end
    n_cmp++;
    if (busy0 !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_sweep_timeout got busy=%b after %0d cycles want 0", busy0, waited);
    end
    for (int pass = 0; pass < 2; pass++) begin
      for (int a = 0; a < DEPTH; a++) begin
        step(0, 0, 0, 0, '0, 1, a);
        n_cmp++;
        if (rd_vld0 !== 1'b1 || rd_dat0 !== CLR || rd_dat1 !== CLR) begin
          n_bad++;
          $display("FAIL sweep_clean pass %0d adr %0d got %h/%h want %h", pass, a, rd_dat0, rd_dat1, CLR);
        end
      end
      step(0, 1, 0, 0, '0, 0, 0);
    end
    $display("test_reset_mid: sweep took %0d cycles", waited);
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_overwrite();
    test_priority();
    test_swap_hazard();
    test_stream();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
